// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (feeder, Duplex_UART, RX consumer).
package uart_pkg;

    localparam int DATA_W       = 7;
    localparam int DEPTH        = 8;
    localparam int FRAME_CYCLES = 10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_feed_state_t;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, full/empty flags and a sticky overflow flag.
// full/empty are decoded from the count, so pointers are allowed to wrap freely.
module sync_fifo #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full_s, empty_s, do_push_s, do_pop_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_s   = (count_q == CW'(0));
    assign do_push_s = wr_en_i && !full_s;
    assign do_pop_s  = pop_i && !empty_s;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (wr_en_i && full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are only meaningful between tail and head, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule : sync_fifo

// File: rtl/uart_tx_feeder.sv
// Buffers host words and issues them to Duplex_UART no faster than one per frame.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W       = uart_pkg::DATA_W,
    parameter int DEPTH        = uart_pkg::DEPTH,
    parameter int FRAME_CYCLES = uart_pkg::FRAME_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       uart_start,
    output logic [DATA_W-1:0]          uart_data
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);

    tx_feed_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              uart_start_q, uart_start_d;
    logic [DATA_W-1:0] uart_data_q, uart_data_d;
    logic              busy_q, busy_d;
    logic              pop_s, empty_s;
    logic [DATA_W-1:0] head_s;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .full_o     (full),
        .empty_o    (empty_s),
        .count_o    (count),
        .overflow_o (overflow)
    );

    // Pacing FSM: pop one word per frame, then count the frame out in WAIT.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        uart_start_d = 1'b0;
        uart_data_d  = uart_data_q;
        pop_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    uart_data_d  = head_s;
                    uart_start_d = 1'b1;
                    cnt_d        = CNT_W'(FRAME_CYCLES - 1);
                    state_d      = WAIT;
                end else begin
                    state_d      = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT);
    end

    // State, frame counter and UART-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            uart_start_q <= 1'b0;
            uart_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            uart_start_q <= uart_start_d;
            uart_data_q  <= uart_data_d;
            busy_q       <= busy_d;
        end
    end

    assign empty      = empty_s;
    assign busy       = busy_q;
    assign uart_start = uart_start_q;
    assign uart_data  = uart_data_q;

endmodule : uart_tx_feeder
